// File: rtl/grid_loader_pkg.sv
// Shared types and ASCII constants for the grid loader.
// The helper classifies bytes that carry a grid cell.
package grid_loader_pkg;

    localparam int unsigned DefDataW   = 8;
    localparam int unsigned DefRowW    = 8;
    localparam int unsigned DefColW    = 4;
    localparam int unsigned DefMaxRows = 256;

    localparam logic [7:0] RollCh  = 8'h40;  // '@'
    localparam logic [7:0] EmptyCh = 8'h2E;  // '.'
    localparam logic [7:0] NlCh    = 8'h0A;
    localparam logic [7:0] CrCh    = 8'h0D;

    typedef enum logic [1:0] {
        StFill,
        StWrite,
        StDone,
        StErr
    } loader_state_t;

    function automatic logic is_cell(input logic [7:0] c);
        return (c == RollCh) || (c == EmptyCh);
    endfunction

endpackage

// File: rtl/grid_loader_packer.sv
// Packs one cell bit per push into a DATA_W-bit chunk, LSB first.
// A flush clears both the data and the bit index, so unfilled bits read as zero.
module chunk_packer
    import grid_loader_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              bit_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] vec_o,
    output logic              last_bit_o,
    output logic              empty_o
);

    localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] vec_q, vec_d;
    logic [IdxW-1:0]   idx_q, idx_d;

    assign last_bit_o = (idx_q == IdxW'(DATA_W - 1));
    assign empty_o    = (idx_q == '0);
    assign vec_o      = vec_q;

    always_comb begin
        vec_d = vec_q;
        idx_d = idx_q;
        if (flush_i) begin
            vec_d = '0;
            idx_d = '0;
        end else if (push_i) begin
            vec_d[idx_q] = bit_i;
            idx_d        = last_bit_o ? '0 : idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vec_q <= '0;
            idx_q <= '0;
        end else begin
            vec_q <= vec_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/grid_loader.sv
// Loads an ASCII '@'/'.' grid stream into main_mem one packed chunk at a time,
// owning the mem port (staging_out) until the whole grid is written or an error occurs.
module grid_loader
    import grid_loader_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ROW_W    = DefRowW,
    parameter int unsigned COL_W    = DefColW,
    parameter int unsigned ROW_BASE = 0,
    parameter int unsigned MAX_ROWS = DefMaxRows
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              char_valid_in,
    input  logic [7:0]        char_in,
    input  logic              last_in,
    output logic              char_ready_out,
    input  logic              mem_ack_in,
    input  logic              mem_busy_in,
    output logic              write_en_out,
    output logic [ROW_W-1:0]  row_addr_out,
    output logic [COL_W-1:0]  col_addr_out,
    output logic [DATA_W-1:0] partial_vec_out,
    output logic              staging_out,
    output logic [15:0]       cols_out,
    output logic [ROW_W-1:0]  rows_out,
    output logic              done_out,
    output logic              err_out
);

    // One spare bit so a full grid of MAX_ROWS rows is countable without wrap.
    localparam int unsigned RowCntW = ROW_W + 1;

    loader_state_t      state_q, state_d;
    logic               active_q;
    logic               write_en_q, write_en_d;
    logic [15:0]        col_q, col_d;
    logic [15:0]        cols_q, cols_d;
    logic [COL_W-1:0]   col_addr_q, col_addr_d;
    logic [RowCntW-1:0] row_q, row_d;
    logic               end_row_q, end_row_d;
    logic               end_input_q, end_input_d;

    logic               accept;
    logic               is_eol;
    logic               row_done;
    logic               input_done;
    logic               pk_push;
    logic               pk_flush;
    logic               pk_last;
    logic               pk_empty;
    logic [DATA_W-1:0]  pk_vec;

    chunk_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk_i      (clock),
        .rst_ni     (reset),
        .push_i     (pk_push),
        .bit_i      (char_in == RollCh),
        .flush_i    (pk_flush),
        .vec_o      (pk_vec),
        .last_bit_o (pk_last),
        .empty_o    (pk_empty)
    );

    assign accept = active_q && (state_q == StFill) && char_valid_in;
    // A trailing '\r' that carries last_in still has to close the pending row.
    assign is_eol = (char_in == NlCh) || ((char_in == CrCh) && last_in);

    always_comb begin
        state_d     = state_q;
        write_en_d  = write_en_q;
        col_d       = col_q;
        cols_d      = cols_q;
        col_addr_d  = col_addr_q;
        row_d       = row_q;
        end_row_d   = end_row_q;
        end_input_d = end_input_q;
        pk_push     = 1'b0;
        pk_flush    = 1'b0;
        row_done    = 1'b0;
        input_done  = 1'b0;

        unique case (state_q)
            StFill: begin
                if (accept) begin
                    if (is_cell(char_in)) begin
                        if ((col_q == '0) && (row_q == RowCntW'(MAX_ROWS))) begin
                            state_d = StErr;
                        end else begin
                            pk_push = 1'b1;
                            col_d   = col_q + 16'd1;
                            if (pk_last || last_in) begin
                                state_d     = StWrite;
                                write_en_d  = !mem_busy_in;
                                end_row_d   = last_in;
                                end_input_d = last_in;
                            end
                        end
                    end else if (is_eol) begin
                        if (col_q == '0) begin
                            if (last_in) begin
                                state_d = StDone;
                            end
                        end else if (pk_empty) begin
                            // Row width is a multiple of DATA_W: its last chunk is already written.
                            row_done   = 1'b1;
                            input_done = last_in;
                        end else begin
                            state_d     = StWrite;
                            write_en_d  = !mem_busy_in;
                            end_row_d   = 1'b1;
                            end_input_d = last_in;
                        end
                    end else if (char_in != CrCh) begin
                        state_d = StErr;
                    end
                end
            end
            StWrite: begin
                if (!write_en_q) begin
                    write_en_d = !mem_busy_in;
                end else if (mem_ack_in) begin
                    write_en_d = 1'b0;
                    pk_flush   = 1'b1;
                    if (end_row_q) begin
                        row_done   = 1'b1;
                        input_done = end_input_q;
                    end else begin
                        col_addr_d = col_addr_q + COL_W'(1);
                        state_d    = StFill;
                    end
                end
            end
            StDone: begin
                write_en_d = 1'b0;
            end
            StErr: begin
                write_en_d = 1'b0;
            end
        endcase

        if (row_done) begin
            if ((row_q != '0) && (col_q != cols_q)) begin
                state_d = StErr;
            end else begin
                if (row_q == '0) begin
                    cols_d = col_q;
                end
                row_d      = row_q + RowCntW'(1);
                col_d      = '0;
                col_addr_d = '0;
                state_d    = input_done ? StDone : StFill;
            end
        end

        if (state_d == StErr) begin
            write_en_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StFill;
            active_q    <= 1'b0;
            write_en_q  <= 1'b0;
            col_q       <= '0;
            cols_q      <= '0;
            col_addr_q  <= '0;
            row_q       <= '0;
            end_row_q   <= 1'b0;
            end_input_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= 1'b1;
            write_en_q  <= write_en_d;
            col_q       <= col_d;
            cols_q      <= cols_d;
            col_addr_q  <= col_addr_d;
            row_q       <= row_d;
            end_row_q   <= end_row_d;
            end_input_q <= end_input_d;
        end
    end

    assign char_ready_out  = active_q && (state_q == StFill);
    assign staging_out     = active_q && ((state_q == StFill) || (state_q == StWrite));
    assign write_en_out    = write_en_q;
    assign row_addr_out    = ROW_W'(ROW_BASE) + row_q[ROW_W-1:0];
    assign col_addr_out    = col_addr_q;
    assign partial_vec_out = pk_vec;
    assign cols_out        = cols_q;
    assign rows_out        = row_q[ROW_W-1:0];
    assign done_out        = (state_q == StDone);
    assign err_out         = (state_q == StErr);

endmodule

// File: tb/tb_grid_loader.sv
// Randomized and directed stimulus for grid_loader, checked against a row/chunk model
// of the grid text and a randomly stalling memory responder.
module tb_grid_loader;
    import grid_loader_pkg::*;

    localparam int DW = 8;
    localparam int RW = 4;
    localparam int CW = 3;
    localparam int RB = 2;
    localparam int MR = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          char_valid_in = 1'b0;
    logic [7:0]    char_in = 8'h00;
    logic          last_in = 1'b0;
    logic          mem_ack_in = 1'b0;
    logic          mem_busy_in = 1'b0;
    logic          char_ready_out, write_en_out, staging_out, done_out, err_out;
    logic [RW-1:0] row_addr_out, rows_out;
    logic [CW-1:0] col_addr_out;
    logic [DW-1:0] partial_vec_out;
    logic [15:0]   cols_out;

    grid_loader #(
        .DATA_W   (DW),
        .ROW_W    (RW),
        .COL_W    (CW),
        .ROW_BASE (RB),
        .MAX_ROWS (MR)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .char_valid_in   (char_valid_in),
        .char_in         (char_in),
        .last_in         (last_in),
        .char_ready_out  (char_ready_out),
        .mem_ack_in      (mem_ack_in),
        .mem_busy_in     (mem_busy_in),
        .write_en_out    (write_en_out),
        .row_addr_out    (row_addr_out),
        .col_addr_out    (col_addr_out),
        .partial_vec_out (partial_vec_out),
        .staging_out     (staging_out),
        .cols_out        (cols_out),
        .rows_out        (rows_out),
        .done_out        (done_out),
        .err_out         (err_out)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] stim[$];
    int exp_row[$], exp_col[$], exp_data[$], m_data[$];
    int cap_row[$], cap_col[$], cap_data[$];
    int m_rows, m_cols;
    bit m_err;

    bit running = 0, no_idle = 0, busy_rand = 1, resp_en = 1;
    int ack_dly = -1, busy_until = 0, ack_at = -1, ack_wait = -1, last_rise_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : 32'hDEAD_BEEF;
    endfunction

    // Reference: chunk k of grid row r holds cells k*DW.. of that row, '@' as 1.
    function automatic void emit(input int r, input int k, input logic [7:0] line[$]);
        int d = 0;
        for (int b = 0; b < DW; b++)
            if ((k * DW + b) < line.size() && line[k * DW + b] == RollCh) d |= (1 << b);
        exp_row.push_back(RB + r);
        exp_col.push_back(k);
        exp_data.push_back(d);
        m_data.push_back(d);
    endfunction

    task automatic build_model();
        logic [7:0] line[$];
        logic [7:0] c;
        int r = 0;
        bit err = 0;
        exp_row.delete(); exp_col.delete(); exp_data.delete(); m_data.delete();
        m_cols = 0;
        for (int i = 0; i <= stim.size() && !err; i++) begin
            c = (i == stim.size()) ? NlCh : stim[i];
            if (c == CrCh) continue;
            if (c == NlCh) begin
                if (line.size() == 0) continue;
                if ((line.size() % DW) != 0) emit(r, line.size() / DW, line);
                if (r != 0 && line.size() != m_cols) err = 1;
                else begin
                    if (r == 0) m_cols = line.size();
                    r++;
                    line.delete();
                end
            end else if (c == RollCh || c == EmptyCh) begin
                if (line.size() == 0 && r == MR) err = 1;
                else begin
                    line.push_back(c);
                    if ((line.size() % DW) == 0) emit(r, line.size() / DW - 1, line);
                end
            end else err = 1;
        end
        m_rows = r;
        m_err  = err;
    endtask

    task automatic set_stim(input string t);
        stim.delete();
        for (int i = 0; i < t.len(); i++) stim.push_back(t[i]);
    endtask

    // Memory side: random busy, random (or fixed) ack delay, optional forced ack.
    initial begin
        forever begin
            @(posedge clock); #1;
            if (!reset) ack_wait = -1;
            if (mem_ack_in) mem_ack_in = 1'b0;
            else if (cyc == ack_at) mem_ack_in = 1'b1;
            else if (resp_en && write_en_out) begin
                if (ack_wait < 0) ack_wait = (ack_dly >= 0) ? ack_dly : int'($urandom_range(0, 3));
                if (ack_wait == 0) begin
                    mem_ack_in = 1'b1;
                    ack_wait = -1;
                end else ack_wait--;
            end
            mem_busy_in = (cyc < busy_until) || (busy_rand && ($urandom_range(0, 3) == 0));
        end
    end

    logic          prev_we = 0, prev_busy = 0, prev_ack = 0;
    logic [RW-1:0] prev_row = '0;
    logic [CW-1:0] prev_col = '0;
    logic [DW-1:0] prev_vec = '0;

    always @(negedge clock) begin
        if (reset && running) check("staging", staging_out, !(done_out || err_out));
        if (write_en_out && !prev_we) begin
            last_rise_cyc = cyc;
            check("we_rise_while_busy", prev_busy, 0);
            check("write_expected", exp_data.size() > 0, 1);
            cap_row.push_back(int'(row_addr_out));
            cap_col.push_back(int'(col_addr_out));
            cap_data.push_back(int'(partial_vec_out));
            if (exp_data.size() > 0) begin
                check("wr_row", row_addr_out, exp_row.pop_front());
                check("wr_col", col_addr_out, exp_col.pop_front());
                check("wr_data", partial_vec_out, exp_data.pop_front());
            end
        end else if (write_en_out && prev_we) begin
            check("hold_row", row_addr_out, prev_row);
            check("hold_col", col_addr_out, prev_col);
            check("hold_data", partial_vec_out, prev_vec);
        end
        if (prev_we && prev_ack) check("we_drop_after_ack", write_en_out, 0);
        prev_we   = write_en_out;
        prev_busy = mem_busy_in;
        prev_ack  = mem_ack_in;
        prev_row  = row_addr_out;
        prev_col  = col_addr_out;
        prev_vec  = partial_vec_out;
    end

    task automatic do_reset();
        running = 0;
        char_valid_in = 1'b0;
        last_in = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_we", write_en_out, 0);
        check("rst_ready", char_ready_out, 0);
        check("rst_staging", staging_out, 0);
        check("rst_done_err", {done_out, err_out}, 0);
        check("rst_rows_cols", {rows_out, cols_out}, 0);
        check("rst_col_vec", {col_addr_out, partial_vec_out}, 0);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 running = 1;
        @(negedge clock);
        check("post_rst_staging", staging_out, 1);
        check("post_rst_ready", char_ready_out, 1);
        @(posedge clock); #1;
    endtask

    task automatic prep();
        build_model();
        cap_row.delete(); cap_col.delete(); cap_data.delete();
        do_reset();
    endtask

    task automatic drive_stream();
        for (int i = 0; i < stim.size(); i++) begin
            bit acc = 0, stop = 0;
            int n = 0;
            if (!no_idle && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
            char_valid_in = 1'b1;
            char_in = stim[i];
            last_in = (i == stim.size() - 1);
            do begin
                @(negedge clock);
                n++;
                acc = char_ready_out;
                stop = err_out;
                @(posedge clock); #1;
            end while (!acc && !stop && n < 150);
            char_valid_in = 1'b0;
            last_in = 1'b0;
            if (!acc) begin
                if (!m_err) check("byte_accept_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic finish_check();
        int n = 0;
        while (!(done_out || err_out) && n < 400) begin @(negedge clock); n++; end
        check("finish_timeout", done_out || err_out, 1);
        repeat (2) @(negedge clock);
        check("done", done_out, !m_err);
        check("err", err_out, m_err);
        check("rows", rows_out, m_rows);
        check("cols", cols_out, m_cols);
        check("writes_left", exp_data.size(), 0);
        check("we_idle", write_en_out, 0);
    endtask

    task automatic run_stream();
        prep();
        drive_stream();
        finish_check();
    endtask

    task automatic gen_random();
        int nrows = $urandom_range(1, 7);
        int w = $urandom_range(1, 20);
        stim.delete();
        for (int r = 0; r < nrows; r++) begin
            int rw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 20)) : w;
            if ($urandom_range(0, 5) == 0) stim.push_back(NlCh);
            for (int c = 0; c < rw; c++) begin
                if ($urandom_range(0, 60) == 0) stim.push_back(8'h78);
                else stim.push_back($urandom_range(0, 1) ? RollCh : EmptyCh);
            end
            if ($urandom_range(0, 3) == 0) stim.push_back(CrCh);
            if (r != nrows - 1 || $urandom_range(0, 1)) stim.push_back(NlCh);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_stim("@.@@\n.@..\n");
        run_stream();
        check("t1_model_n", m_data.size(), 2);
        check("t1_model_d0", qget(m_data, 0), 32'h0D);
        check("t1_model_d1", qget(m_data, 1), 32'h02);
        check("t1_dut_d0", qget(cap_data, 0), 32'h0D);
        check("t1_dut_row1", qget(cap_row, 1), RB + 1);
        check("t1_cols_rows", {cols_out, 4'(rows_out)}, {16'd4, 4'd2});

        set_stim("@@@@@@@@@@\n");
        run_stream();
        check("t2_n", cap_data.size(), 2);
        check("t2_d0", qget(cap_data, 0), 32'hFF);
        check("t2_d1", qget(cap_data, 1), 32'h03);
        check("t2_col1", qget(cap_col, 1), 1);

        set_stim("@.@@\n");
        busy_rand = 0; ack_dly = 3; no_idle = 1;
        prep();
        busy_until = cyc + 7;
        drive_stream();
        finish_check();
        check("t3_rise_after_busy", last_rise_cyc > busy_until, 1);
        check("t3_d0", qget(cap_data, 0), 32'h0D);
        busy_rand = 1; ack_dly = -1; no_idle = 0;

        set_stim("@@@\n@@\n");
        run_stream();
        check("t4_err", err_out, 1);
        check("t4_done", done_out, 0);
        check("t4_staging", staging_out, 0);
        check("t4_rows", rows_out, 1);
        set_stim("@x");
        run_stream();
        check("t4b_err", err_out, 1);
        check("t4b_writes", cap_data.size(), 0);

        set_stim("..@");
        run_stream();
        check("t5_d0", qget(cap_data, 0), 32'h04);
        check("t5_done", done_out, 1);
        set_stim("@@\n\n\n");
        run_stream();
        check("t5b_rows", rows_out, 1);
        set_stim("\n");
        run_stream();
        check("empty_done", done_out, 1);
        set_stim("@\n@\n@\n@\n@\n@\n@\n");
        run_stream();
        check("ovf_err", err_out, 1);
        check("ovf_rows", rows_out, MR);
        set_stim("@@@@@@@@@@@@@@@@\r");
        run_stream();
        check("cr_last_rows", rows_out, 1);

        set_stim("@@@@@@@@");
        resp_en = 0; busy_rand = 0;
        prep();
        drive_stream();
        for (int n = 0; n < 50 && !write_en_out; n++) @(negedge clock);
        check("t6_we_seen", write_en_out, 1);
        @(posedge clock); #1 reset = 1'b0; running = 0;
        @(posedge clock);
        @(negedge clock);
        check("t6_we", write_en_out, 0);
        check("t6_flags", {char_ready_out, staging_out, done_out, err_out}, 0);
        check("t6_vec", partial_vec_out, 0);
        @(posedge clock); #1 reset = 1'b1;
        ack_at = cyc + 2;
        repeat (5) @(negedge clock);
        check("t6_ack_ignored", {write_en_out, 4'(rows_out), 3'(col_addr_out)}, 0);
        check("t6_ready", char_ready_out, 1);
        check("t6_left", exp_data.size(), 0);
        resp_en = 1; busy_rand = 1; ack_at = -1;
        set_stim("@.\n");
        run_stream();
        check("t6_row_base", qget(cap_row, 0), RB);

        for (int t = 0; t < 40; t++) begin
            gen_random();
            run_stream();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
